// File: rtl/ms_stopwatch.sv
// ms_stopwatch: millisecond stopwatch with saturation and an optional BCD mirror.
//
// A start pulse opens a measurement. A free-running cycle counter divides clk
// down to millisecond ticks, and each tick advances elapsed_ms. The measurement
// ends on a stop pulse or when the count saturates at MAX_MS. Results then hold
// in DONE until start, clear or reset.
//
// Parameters:
//   MAX_MS       largest reportable count in ms (at most 9999)
//   CLKS_PER_MS  clk cycles per millisecond (at least 2)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   start        single-cycle request to begin a measurement (ignored in RUN)
//   stop         single-cycle request to end a measurement (RUN only)
//   clear        synchronous return to IDLE with zeroed results
//   elapsed_ms   elapsed milliseconds, binary
//   elapsed_bcd  elapsed milliseconds as 4 BCD digits, [15:12] = thousands
//   running      high while in RUN
//   valid        high while in DONE
//   overflow     high in DONE when the count saturated at MAX_MS
//
// Build option: define STOPWATCH_BCD_EN to keep elapsed_bcd as a BCD counter.
// Without it, elapsed_bcd is tied to zero and no BCD logic is built.
//
// state | meaning
// IDLE  | no measurement; all outputs zero
// RUN   | counting clk cycles and milliseconds
// DONE  | measurement finished; results frozen

module ms_stopwatch #(
    parameter int MAX_MS      = 9999,
    parameter int CLKS_PER_MS = 50000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         clear,
    output logic [$clog2(MAX_MS+1)-1:0]  elapsed_ms,
    output logic [15:0]                  elapsed_bcd,
    output logic                         running,
    output logic                         valid,
    output logic                         overflow
);

    localparam int W  = $clog2(MAX_MS + 1);
    localparam int CW = $clog2(CLKS_PER_MS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_MS - 1);
    localparam logic [W-1:0]  MS_MAX   = W'(MAX_MS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cyc_cnt;
    logic            tick;
    logic            zero_all;
    logic            bump;

    assign tick = (state == RUN) && (cyc_cnt == CNT_LAST);

    // zero_all covers reset, clear and the start of a new measurement. bump is
    // a tick that still has room to count. Both are shared with the BCD counter
    // so that it moves on exactly the same edges as elapsed_ms.
    assign zero_all = !reset || clear || ((state != RUN) && start);
    assign bump     = tick && (elapsed_ms != MS_MAX);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            elapsed_ms <= '0;
            running    <= 1'b0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        cyc_cnt    <= '0;
                        elapsed_ms <= '0;
                        running    <= 1'b1;
                        valid      <= 1'b0;
                        overflow   <= 1'b0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        cyc_cnt <= '0;
                        if (bump) begin
                            elapsed_ms <= elapsed_ms + W'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                    // A stop on a tick edge still takes that tick's
                    // increment (or saturation) above before freezing.
                    if (stop || (tick && !bump)) begin
                        state   <= DONE;
                        running <= 1'b0;
                        valid   <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    valid   <= 1'b0;
                end
            endcase
        end
    end

`ifdef STOPWATCH_BCD_EN
    logic [15:0] bcd_next;

    // Ripple a decimal carry through the digits. The thousands digit never
    // wraps, because no increment happens at MAX_MS and MAX_MS is at most 9999.
    always_comb begin
        bcd_next = elapsed_bcd;
        if (elapsed_bcd[3:0] != 4'd9) begin
            bcd_next[3:0] = elapsed_bcd[3:0] + 4'd1;
        end else begin
            bcd_next[3:0] = 4'd0;
            if (elapsed_bcd[7:4] != 4'd9) begin
                bcd_next[7:4] = elapsed_bcd[7:4] + 4'd1;
            end else begin
                bcd_next[7:4] = 4'd0;
                if (elapsed_bcd[11:8] != 4'd9) begin
                    bcd_next[11:8] = elapsed_bcd[11:8] + 4'd1;
                end else begin
                    bcd_next[11:8]  = 4'd0;
                    bcd_next[15:12] = elapsed_bcd[15:12] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (zero_all) begin
            elapsed_bcd <= 16'h0000;
        end else if (bump) begin
            elapsed_bcd <= bcd_next;
        end
    end
`else
    logic unused_bcd;
    assign unused_bcd  = zero_all;
    assign elapsed_bcd = 16'h0000;
`endif

endmodule
